// File: rtl/pe_traffic_gen.sv
// pe_traffic_gen
// ---------------------------------------------------------------------------
// Traffic generator and sink for one Hoplite torus PE. It injects NUM_PKTS
// packets towards the switch, paced by a token bucket. The bucket gains one
// token every RATE cycles and holds at most MAX_TOKEN tokens. On the receive
// side it counts every packet delivered by the switch South exit, and counts
// separately the packets whose destination is not this PE.
//
// Packet layout, LSB first:
//   dst_x[X_AW] | dst_y[Y_AW] | src_x[X_AW] | src_y[Y_AW] | seq[SEQ_W]
//   where SEQ_W = P_W - 2*(X_AW+Y_AW)
//
// Ports
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   in_pkt    in   [P_W]   packet delivered by the switch South exit
//   in_vld    in   in_pkt valid (the sink never stalls)
//   sw_rdy    in   switch accepts an injection this cycle
//   out_pkt   out  [P_W]   injected packet
//   out_vld   out  out_pkt valid
//   sent_cnt  out  [CNT_W] packets accepted by the switch (saturating)
//   recv_cnt  out  [CNT_W] packets received (saturating)
//   err_cnt   out  [CNT_W] received packets with wrong destination (saturating)
//   done      out  all NUM_PKTS injected
//
// Injection handshake: a transfer happens in any cycle where out_vld and
// sw_rdy are both high. out_vld does not depend on sw_rdy. Once out_vld rises,
// out_pkt stays stable and out_vld stays high until the transfer happens.
// ---------------------------------------------------------------------------
module pe_traffic_gen #(
    parameter int          P_W       = 16,
    parameter int          X_AW      = 2,
    parameter int          Y_AW      = 2,
    parameter int          X_POS     = 0,
    parameter int          Y_POS     = 0,
    parameter int          MODE      = 0,
    parameter int          FIX_X     = 1,
    parameter int          FIX_Y     = 0,
    parameter int          RATE      = 1,
    parameter int          MAX_TOKEN = 1,
    parameter int          NUM_PKTS  = 16,
    parameter int          START_DLY = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   in_pkt,
    input  logic             in_vld,
    input  logic             sw_rdy,
    output logic [P_W-1:0]   out_pkt,
    output logic             out_vld,
    output logic [CNT_W-1:0] sent_cnt,
    output logic [CNT_W-1:0] recv_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             done
);

    localparam int A_W    = X_AW + Y_AW;
    localparam int SEQ_W  = P_W - 2 * A_W;
    localparam int RATE_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int TOK_W  = $clog2(MAX_TOKEN + 1);
    localparam int DLY_W  = (START_DLY > 1) ? $clog2(START_DLY) : 1;

    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              accept;
    logic              rate_wrap;
    logic [X_AW-1:0]   dst_x;
    logic [Y_AW-1:0]   dst_y;
    logic [X_AW-1:0]   rx_dst_x;
    logic [Y_AW-1:0]   rx_dst_y;
    logic              rx_unused;

    // -----------------------------------------------------------------------
    // FSM: next state and the outputs that depend only on registered state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        out_vld    = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;

        case (state_q)
            ST_WAIT: begin
                // WAIT always lasts at least the first cycle after reset.
                // START_DLY=0 and START_DLY=1 both reach RUN after one cycle.
                // START_DLY=N (N>1) reaches RUN after N cycles.
                if ((32'(wait_cnt_q) + 32'd1) >= 32'(START_DLY)) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                out_vld = (tok_cnt_q != '0);
                accept  = out_vld & sw_rdy;
                if (accept && ((32'(sent_cnt_q) + 32'd1) == 32'(NUM_PKTS))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Destination selection for the packet currently on offer
    // -----------------------------------------------------------------------
    always_comb begin
        dst_x = '0;
        dst_y = '0;
        if (MODE == 0) begin
            dst_x = lfsr_q[X_AW-1:0];
            dst_y = lfsr_q[A_W-1:X_AW];
            // A random draw that lands on this PE is redirected one column
            // over, so no packet is ever addressed to its own source.
            if ((dst_x == X_AW'(X_POS)) && (dst_y == Y_AW'(Y_POS))) begin
                dst_x = X_AW'(X_POS + 1);
            end
        end else if (MODE == 1) begin
            dst_x = X_AW'(FIX_X);
            dst_y = Y_AW'(FIX_Y);
        end else begin
            dst_x = X_AW'(Y_POS);
            dst_y = Y_AW'(X_POS);
        end
    end

    // seq and lfsr change only on accept, so out_pkt stays stable while stalled.
    assign out_pkt = {seq_q, Y_AW'(Y_POS), X_AW'(X_POS), dst_y, dst_x};

    // -----------------------------------------------------------------------
    // Receive-side field extraction; only the destination is checked
    // -----------------------------------------------------------------------
    assign rx_dst_x  = in_pkt[X_AW-1:0];
    assign rx_dst_y  = in_pkt[A_W-1:X_AW];
    assign rx_unused = ^in_pkt[P_W-1:A_W];

    // -----------------------------------------------------------------------
    // Datapath next-state: token bucket, sequence/LFSR, statistics
    // -----------------------------------------------------------------------
    always_comb begin
        rate_cnt_d = rate_cnt_q;
        tok_cnt_d  = tok_cnt_q;
        lfsr_d     = lfsr_q;
        seq_d      = seq_q;
        sent_cnt_d = sent_cnt_q;
        recv_cnt_d = recv_cnt_q;
        err_cnt_d  = err_cnt_q;

        // The refill timer runs in every state, including WAIT and DONE.
        rate_wrap  = (rate_cnt_q == RATE_W'(RATE - 1));
        rate_cnt_d = rate_wrap ? '0 : rate_cnt_q + 1'b1;

        // If a refill and a consume happen in the same cycle, they cancel.
        // The bucket stays unchanged, even when it is full.
        case ({rate_wrap, accept})
            2'b10: begin
                if (tok_cnt_q != TOK_W'(MAX_TOKEN)) begin
                    tok_cnt_d = tok_cnt_q + 1'b1;
                end
            end
            2'b01: begin
                tok_cnt_d = tok_cnt_q - 1'b1;
            end
            default: begin
                tok_cnt_d = tok_cnt_q;
            end
        endcase

        if (accept) begin
            seq_d  = seq_q + 1'b1;
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
            if (sent_cnt_q != CNT_MAX) begin
                sent_cnt_d = sent_cnt_q + 1'b1;
            end
        end

        if (in_vld) begin
            if (recv_cnt_q != CNT_MAX) begin
                recv_cnt_d = recv_cnt_q + 1'b1;
            end
            if ((rx_dst_x != X_AW'(X_POS)) || (rx_dst_y != Y_AW'(Y_POS))) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= '0;
            rate_cnt_q <= '0;
            tok_cnt_q  <= TOK_W'(MAX_TOKEN);
            lfsr_q     <= LFSR_SEED;
            seq_q      <= '0;
            sent_cnt_q <= '0;
            recv_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rate_cnt_q <= rate_cnt_d;
            tok_cnt_q  <= tok_cnt_d;
            lfsr_q     <= lfsr_d;
            seq_q      <= seq_d;
            sent_cnt_q <= sent_cnt_d;
            recv_cnt_q <= recv_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign sent_cnt = sent_cnt_q;
    assign recv_cnt = recv_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Bench for pe_traffic_gen. It instantiates three differently configured
// generators:
//   u_a  fixed destination, one packet per cycle, short budget, receive check
//   u_b  random destination, slow bucket, start delay, randomised handshake
//   u_c  transpose destination, reset mid-burst and rerun comparison
// A behavioural model tracks each instance from the rules (cycles since
// reset, tokens, packets sent, LFSR stepped once per packet) and is compared
// against the DUT on every cycle. Literal expectations pin the model.
module tb_pe_traffic_gen;

    localparam int NI    = 3;
    localparam int T_RUN = 400;

    localparam int          C_MODE [NI] = '{1, 0, 2};
    localparam int          C_XPOS [NI] = '{0, 1, 1};
    localparam int          C_YPOS [NI] = '{0, 2, 2};
    localparam int          C_FIXX [NI] = '{1, 1, 1};
    localparam int          C_FIXY [NI] = '{0, 0, 0};
    localparam int          C_RATE [NI] = '{1, 4, 2};
    localparam int          C_MAXT [NI] = '{1, 3, 2};
    localparam int          C_NUM  [NI] = '{4, 60, 12};
    localparam int          C_DLY  [NI] = '{0, 5, 0};
    localparam logic [15:0] C_SEED [NI] = '{16'hACE1, 16'h1D2B, 16'hACE1};

    // ---------------- clock ----------------
    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic        rst      [NI];
    logic [15:0] in_pkt   [NI];
    logic        in_vld   [NI];
    logic        sw_rdy   [NI];
    logic [15:0] out_pkt  [NI];
    logic        out_vld  [NI];
    logic [15:0] sent_cnt [NI];
    logic [15:0] recv_cnt [NI];
    logic [15:0] err_cnt  [NI];
    logic        done     [NI];

    pe_traffic_gen #(
        .P_W(16), .X_AW(2), .Y_AW(2), .X_POS(C_XPOS[0]), .Y_POS(C_YPOS[0]),
        .MODE(C_MODE[0]), .FIX_X(C_FIXX[0]), .FIX_Y(C_FIXY[0]),
        .RATE(C_RATE[0]), .MAX_TOKEN(C_MAXT[0]), .NUM_PKTS(C_NUM[0]),
        .START_DLY(C_DLY[0]), .LFSR_SEED(C_SEED[0]), .CNT_W(16)
    ) u_a (
        .clk(clk), .rst(rst[0]), .in_pkt(in_pkt[0]), .in_vld(in_vld[0]),
        .sw_rdy(sw_rdy[0]), .out_pkt(out_pkt[0]), .out_vld(out_vld[0]),
        .sent_cnt(sent_cnt[0]), .recv_cnt(recv_cnt[0]), .err_cnt(err_cnt[0]),
        .done(done[0])
    );

    pe_traffic_gen #(
        .P_W(16), .X_AW(2), .Y_AW(2), .X_POS(C_XPOS[1]), .Y_POS(C_YPOS[1]),
        .MODE(C_MODE[1]), .FIX_X(C_FIXX[1]), .FIX_Y(C_FIXY[1]),
        .RATE(C_RATE[1]), .MAX_TOKEN(C_MAXT[1]), .NUM_PKTS(C_NUM[1]),
        .START_DLY(C_DLY[1]), .LFSR_SEED(C_SEED[1]), .CNT_W(16)
    ) u_b (
        .clk(clk), .rst(rst[1]), .in_pkt(in_pkt[1]), .in_vld(in_vld[1]),
        .sw_rdy(sw_rdy[1]), .out_pkt(out_pkt[1]), .out_vld(out_vld[1]),
        .sent_cnt(sent_cnt[1]), .recv_cnt(recv_cnt[1]), .err_cnt(err_cnt[1]),
        .done(done[1])
    );

    pe_traffic_gen #(
        .P_W(16), .X_AW(2), .Y_AW(2), .X_POS(C_XPOS[2]), .Y_POS(C_YPOS[2]),
        .MODE(C_MODE[2]), .FIX_X(C_FIXX[2]), .FIX_Y(C_FIXY[2]),
        .RATE(C_RATE[2]), .MAX_TOKEN(C_MAXT[2]), .NUM_PKTS(C_NUM[2]),
        .START_DLY(C_DLY[2]), .LFSR_SEED(C_SEED[2]), .CNT_W(16)
    ) u_c (
        .clk(clk), .rst(rst[2]), .in_pkt(in_pkt[2]), .in_vld(in_vld[2]),
        .sw_rdy(sw_rdy[2]), .out_pkt(out_pkt[2]), .out_vld(out_vld[2]),
        .sent_cnt(sent_cnt[2]), .recv_cnt(recv_cnt[2]), .err_cnt(err_cnt[2]),
        .done(done[2])
    );

    // ---------------- behavioural model ----------------
    int          m_cyc  [NI];   // clock edges since the last reset edge
    int          m_sent [NI];
    int          m_tok  [NI];
    int          m_recv [NI];
    int          m_err  [NI];
    logic [15:0] m_lfsr [NI];   // seed advanced once per accepted packet

    function automatic logic [15:0] lfsr_next(logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic bit m_vld(int i);
        int wait_len;
        wait_len = (C_DLY[i] > 1) ? C_DLY[i] : 1;
        return (m_cyc[i] >= wait_len) && (m_sent[i] < C_NUM[i]) && (m_tok[i] != 0);
    endfunction

    function automatic logic [15:0] m_pkt(int i);
        int dx, dy, xp, yp;
        xp = C_XPOS[i];
        yp = C_YPOS[i];
        case (C_MODE[i])
            0: begin
                dx = int'(m_lfsr[i][1:0]);
                dy = int'(m_lfsr[i][3:2]);
                if (dx == xp && dy == yp) dx = (xp + 1) % 4;
            end
            1: begin
                dx = C_FIXX[i] % 4;
                dy = C_FIXY[i] % 4;
            end
            default: begin
                dx = yp % 4;
                dy = xp % 4;
            end
        endcase
        return {8'(m_sent[i] % 256), 2'(yp), 2'(xp), 2'(dy), 2'(dx)};
    endfunction

    task automatic model_step(int i, logic r, logic rdy, logic iv, logic [15:0] ip);
        bit acc;
        if (r) begin
            m_cyc[i]  = 0;
            m_sent[i] = 0;
            m_tok[i]  = C_MAXT[i];
            m_recv[i] = 0;
            m_err[i]  = 0;
            m_lfsr[i] = C_SEED[i];
        end else begin
            acc = m_vld(i) && rdy;
            m_cyc[i] = m_cyc[i] + 1;
            m_tok[i] = m_tok[i] + (((m_cyc[i] % C_RATE[i]) == 0) ? 1 : 0) - (acc ? 1 : 0);
            if (m_tok[i] > C_MAXT[i]) m_tok[i] = C_MAXT[i];
            if (acc) begin
                m_sent[i] = m_sent[i] + 1;
                m_lfsr[i] = lfsr_next(m_lfsr[i]);
            end
            if (iv) begin
                if (m_recv[i] < 65535) m_recv[i] = m_recv[i] + 1;
                if ((ip[1:0] != 2'(C_XPOS[i])) || (ip[3:2] != 2'(C_YPOS[i]))) begin
                    if (m_err[i] < 65535) m_err[i] = m_err[i] + 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_err;
    int          t_now;
    logic [15:0] exp_q[$];

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s[%0d] t=%0d got=%0h want=%0h", name, i, t_now, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check("out_vld", i, 32'(out_vld[i]), 32'(m_vld(i)));
            check("done", i, 32'(done[i]), 32'(m_sent[i] == C_NUM[i]));
            check("sent_cnt", i, 32'(sent_cnt[i]), 32'(m_sent[i]));
            check("recv_cnt", i, 32'(recv_cnt[i]), 32'(m_recv[i]));
            check("err_cnt", i, 32'(err_cnt[i]), 32'(m_err[i]));
            if (m_vld(i)) check("out_pkt", i, 32'(out_pkt[i]), 32'(m_pkt(i)));
        end
    endtask

    // ---------------- driver ----------------
    logic        b_prev_stall;
    logic [15:0] b_prev_pkt;
    bit          exp_acc;

    initial begin
        n_vec = 0;
        n_err = 0;
        t_now = -1;
        b_prev_stall = 1'b0;
        b_prev_pkt   = '0;
        for (int i = 0; i < NI; i++) begin
            rst[i]    = 1'b1;
            in_vld[i] = 1'b0;
            in_pkt[i] = '0;
            sw_rdy[i] = 1'b0;
        end

        repeat (2) begin
            for (int i = 0; i < NI; i++) model_step(i, 1'b1, 1'b0, 1'b0, 16'h0);
            @(posedge clk);
            #1;
        end

        for (int t = 0; t < T_RUN; t++) begin
            t_now = t;
            compare_all();

            // reset state, literal
            if (t == 0) begin
                for (int i = 0; i < NI; i++) begin
                    check("rst_vld", i, 32'(out_vld[i]), 32'd0);
                    check("rst_done", i, 32'(done[i]), 32'd0);
                    check("rst_sent", i, 32'(sent_cnt[i]), 32'd0);
                end
            end

            // u_a: four consecutive packets, seq 0..3, dst (1,0)
            if (t >= 1 && t <= 4) begin
                check("a_vld", 0, 32'(out_vld[0]), 32'd1);
                check("a_pkt", 0, 32'(out_pkt[0]), 32'({8'(t - 1), 8'h01}));
            end
            if (t == 5) begin
                check("a_done", 0, 32'(done[0]), 32'd1);
                check("a_sent", 0, 32'(sent_cnt[0]), 32'd4);
                check("a_vld_off", 0, 32'(out_vld[0]), 32'd0);
            end
            if (t == 8) begin
                check("a_recv", 0, 32'(recv_cnt[0]), 32'd2);
                check("a_err", 0, 32'(err_cnt[0]), 32'd1);
            end

            // u_b: start delay of 5 cycles
            if (t == 4) check("b_dly_off", 1, 32'(out_vld[1]), 32'd0);
            if (t == 5) check("b_dly_on", 1, 32'(out_vld[1]), 32'd1);
            if (b_prev_stall && out_vld[1])
                check("b_hold", 1, 32'(out_pkt[1]), 32'(b_prev_pkt));
            if (out_vld[1])
                check("b_notself", 1, 32'(out_pkt[1][3:0] == 4'b1001), 32'd0);

            // u_c: state right after the mid-burst reset
            if (t == 7) begin
                check("c_rst_vld", 2, 32'(out_vld[2]), 32'd0);
                check("c_rst_sent", 2, 32'(sent_cnt[2]), 32'd0);
            end

            // ---- drive inputs for this cycle ----
            rst[0]    = 1'b0;
            sw_rdy[0] = 1'b1;
            in_vld[0] = (t == 6) || (t == 7);
            in_pkt[0] = (t == 6) ? 16'h0000 : 16'h0006;

            rst[1] = 1'b0;
            if (t < 20)       sw_rdy[1] = 1'b0;
            else if (t < 60)  sw_rdy[1] = 1'b1;
            else if (t < 120) sw_rdy[1] = (t % 2 == 0);
            else              sw_rdy[1] = 1'($urandom_range(0, 1));
            in_vld[1] = ($urandom_range(0, 9) < 4);
            in_pkt[1] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) in_pkt[1][3:0] = 4'b1001;

            rst[2]    = (t == 6);
            sw_rdy[2] = 1'b1;
            in_vld[2] = (t >= 20) && ($urandom_range(0, 2) == 0);
            in_pkt[2] = 16'($urandom);

            // u_b: full bucket of 3 drains back-to-back, then refill-paced
            if (t >= 20 && t <= 32) begin
                exp_acc = (t == 20) || (t == 21) || (t == 22) ||
                          (t == 24) || (t == 28) || (t == 32);
                check("b_acc_cyc", 1, 32'(out_vld[1] && sw_rdy[1]), 32'(exp_acc));
            end

            // u_c: record the first run, replay it against the rerun
            if (out_vld[2] && sw_rdy[2] && !rst[2]) begin
                if (t < 6) exp_q.push_back(out_pkt[2]);
                else if (t > 6 && exp_q.size() > 0)
                    check("c_rerun", 2, 32'(out_pkt[2]), 32'(exp_q.pop_front()));
            end

            b_prev_stall = out_vld[1] && !sw_rdy[1];
            b_prev_pkt   = out_pkt[1];

            for (int i = 0; i < NI; i++)
                model_step(i, rst[i], sw_rdy[i], in_vld[i], in_pkt[i]);

            @(posedge clk);
            #1;
        end

        t_now = T_RUN;
        compare_all();
        for (int i = 0; i < NI; i++) check("end_done", i, 32'(done[i]), 32'd1);
        check("c_trace_left", 2, 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pe_traffic_gen.md
Name: pe_traffic_gen

Overview:
- Parametrised successor to the PE test wrapper: a self-contained traffic generator and sink for one Hoplite torus PE.
- Replaces the free-running rate counter with a token-bucket regulator: configurable refill period and burst depth.
- Adds selectable destination modes, a packet budget with start delay, and receive-side checking with statistics counters.
- Sits on the PE side of one switch: injection port to switch, South-exit port from switch.

Parameters:
P_W, 16, packet width; must be >= 2*(X_AW+Y_AW)+1
X_AW, 2, X address width of torus
Y_AW, 2, Y address width of torus
X_POS, 0, X position of this PE
Y_POS, 0, Y position of this PE
MODE, 0, 0 = uniform random dest, 1 = fixed dest, 2 = transpose
FIX_X, 1, destination X for MODE 1
FIX_Y, 0, destination Y for MODE 1
RATE, 1, refill period in cycles (>= 1); one token added per RATE cycles
MAX_TOKEN, 1, bucket depth / max burst (>= 1)
NUM_PKTS, 16, packets to inject before DONE (>= 1)
START_DLY, 0, cycles spent in WAIT after reset
LFSR_SEED, 16'hACE1, nonzero 16-bit LFSR seed
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_pkt  in  P_W  packet delivered by switch South exit
in_vld  in  1  in_pkt valid
sw_rdy  in  1  switch accepts injection this cycle
out_pkt  out  P_W  injected packet
out_vld  out  1  out_pkt valid
sent_cnt  out  CNT_W  packets accepted by switch
recv_cnt  out  CNT_W  packets received
err_cnt  out  CNT_W  received packets with wrong destination
done  out  1  all NUM_PKTS injected

Behaviour:
- One clock; reset is synchronous and active-high; all state updates on rising clk.
- Packet format, LSB first: dst_x[X_AW], dst_y[Y_AW], src_x[X_AW], src_y[Y_AW], seq[SEQ_W], with SEQ_W = P_W-2*(X_AW+Y_AW).
- Reset values: out_vld=0, done=0, all counters 0, seq=0, lfsr=LFSR_SEED, tok_cnt=MAX_TOKEN, rate_cnt=0, state=WAIT.
- Reset asserted mid-operation: same values next cycle; any in-flight offer is dropped.
- FSM WAIT: counts START_DLY cycles, then RUN. START_DLY=0 gives RUN on the first cycle after reset deasserts.
- FSM RUN: goes to DONE on the accept that makes sent_cnt==NUM_PKTS.
- FSM DONE: terminal; done=1, out_vld=0.
- Injection: out_vld = (state==RUN) & (tok_cnt!=0), combinational from registered state.
- Accept = out_vld & sw_rdy. out_pkt is held stable until accepted.
- On accept: seq+1 (wraps mod 2^SEQ_W), lfsr advances one step, sent_cnt+1, tok_cnt-1.
- Token bucket: rate_cnt counts 0..RATE-1 and wraps. On wrap, tok_cnt+1, saturating at MAX_TOKEN.
- Refill and consume in the same cycle: tok_cnt unchanged.
- RATE=1, MAX_TOKEN=1 with sw_rdy held high gives one packet per cycle.
- The bucket refills in every state.
- Destination, MODE 0: dst = lfsr low bits; x = lfsr[X_AW-1:0], y = lfsr[X_AW+Y_AW-1:X_AW].
- MODE 0 self-destination: if dst equals (X_POS,Y_POS), dst_x is replaced by X_POS+1 mod 2^X_AW.
- Destination, MODE 1: (FIX_X,FIX_Y).
- Destination, MODE 2: (Y_POS,X_POS) truncated to field widths.
- LFSR: 16-bit Galois, taps 0xB400. It advances only on accept.
- Receive: each in_vld cycle increments recv_cnt, independent of state and of concurrent injection.
- Receive check: if dst_x!=X_POS or dst_y!=Y_POS, err_cnt+1 as well.
- Statistics counters saturate at all-ones.

Test Plan:
- RATE=1, MAX_TOKEN=1, NUM_PKTS=4, MODE=1 (1,0), sw_rdy=1 -> out_vld on 4 consecutive cycles; seq 0,1,2,3; out_pkt[3:0]=4'b0001; done=1 on the next cycle; sent_cnt=4.
- RATE=4, MAX_TOKEN=3, sw_rdy=0 for 20 cycles then 1 -> 3 back-to-back packets, then one packet every 4 cycles.
- sw_rdy toggles 1/0 each cycle, MODE 0 -> out_pkt unchanged while out_vld=1 & sw_rdy=0; no dst equals (X_POS,Y_POS); LFSR steps only on accepts.
- Inject in_vld with dst (0,0), then (2,1), at X_POS=Y_POS=0 -> recv_cnt=2, err_cnt=1.
- START_DLY=5 -> first out_vld exactly 5 cycles after reset deasserts.
- Assert rst for 1 cycle mid-burst -> next cycle out_vld=0, counters=0, seq=0; the run restarts and is bit-identical to the first run.
